// File: rtl/zx_bus_pkg.sv
// Shared types and constants for the ZX edge-connector front end.
package zx_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      QUAL,
      ACTIVE_RD,
      ACTIVE_WR,
      RECOVER
   } state_t;

   typedef enum logic {
      KIND_RD,
      KIND_WR
   } kind_t;

   localparam int SYNC_STAGES_DEF   = 2;
   localparam int SETTLE_CYCLES_DEF = 3;

   localparam logic [1:0] ROM_A15_14 = 2'b00;

   function automatic logic in_rom(input logic [15:0] addr);
      return addr[15:14] == ROM_A15_14;
   endfunction

endpackage

// File: rtl/zx_sync_bit.sv
// N-flop synchroniser for one active-low Z80 strobe; resets to the inactive (high) level.
module zx_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk32,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '1;
      end else begin
         sr <= {sr[STAGES-2:0], din};
      end
   end

   assign dout = sr[STAGES-1];

endmodule

// File: rtl/zx_io_cycle_detect.sv
// Derives qualified Z80 I/O read/write cycles from n_rd/n_wr (n_iorq is unusable on the host)
// and tracks whether the last opcode fetch came from the ROM window.
module zx_io_cycle_detect
   import zx_bus_pkg::*;
#(
   parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
   input  logic        clk32,
   input  logic        rst_n,
   input  logic [15:0] a,
   input  logic [7:0]  d,
   input  logic        n_rd,
   input  logic        n_wr,
   input  logic        n_mreq,
   input  logic        n_m1,
   output logic        io_rd,
   output logic        io_wr,
   output logic        rd_stb,
   output logic        wr_stb,
   output logic [15:0] io_addr,
   output logic [7:0]  io_data,
   output logic        rom_m1_access,
   output logic        busy
);

   localparam int ARM_W = $clog2(SYNC_STAGES + 1) + 1;

   logic rd_s, wr_s, mreq_s, m1_s;

   zx_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rd   (.clk32(clk32), .rst_n(rst_n), .din(n_rd),   .dout(rd_s));
   zx_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_wr   (.clk32(clk32), .rst_n(rst_n), .din(n_wr),   .dout(wr_s));
   zx_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_mreq (.clk32(clk32), .rst_n(rst_n), .din(n_mreq), .dout(mreq_s));
   zx_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_m1   (.clk32(clk32), .rst_n(rst_n), .din(n_m1),   .dout(m1_s));

   logic [15:0] a_q;
   logic [7:0]  d_q;

   always_ff @(posedge clk32) begin
      a_q <= a;
      d_q <= d;
   end

   logic cond_rd, cond_wr, kind_cond;
   assign cond_rd = !rd_s &&  wr_s && mreq_s && m1_s;
   assign cond_wr =  rd_s && !wr_s && mreq_s && m1_s;

   // The synchronisers come out of reset reading "idle", so the bus only counts as
   // genuinely idle after SYNC_STAGES+1 consecutive high samples; this keeps a cycle
   // already in flight at reset release from producing a strobe.
   logic             armed;
   logic [ARM_W-1:0] arm_cnt;

   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) begin
         armed   <= 1'b0;
         arm_cnt <= '0;
      end else if (!armed) begin
         if (rd_s && wr_s) begin
            if (arm_cnt == ARM_W'(SYNC_STAGES)) begin
               armed <= 1'b1;
            end else begin
               arm_cnt <= arm_cnt + ARM_W'(1);
            end
         end else begin
            arm_cnt <= '0;
         end
      end
   end

   state_t     state, state_nx;
   kind_t      kind, kind_nx;
   logic [3:0] cnt, cnt_nx;
   logic       acc_rd, acc_wr;

   assign kind_cond = (kind == KIND_WR) ? cond_wr : cond_rd;

   always_comb begin
      state_nx = state;
      kind_nx  = kind;
      cnt_nx   = cnt;
      acc_rd   = 1'b0;
      acc_wr   = 1'b0;
      case (state)
         IDLE: begin
            if (armed && (cond_rd || cond_wr)) begin
               state_nx = QUAL;
               cnt_nx   = 4'd1;
               kind_nx  = cond_wr ? KIND_WR : KIND_RD;
            end
         end
         QUAL: begin
            // cnt counts synced samples already seen holding; the last one decides acceptance
            if (cnt == 4'(SETTLE_CYCLES)) begin
               if (kind == KIND_WR) begin
                  state_nx = ACTIVE_WR;
                  acc_wr   = 1'b1;
               end else begin
                  state_nx = ACTIVE_RD;
                  acc_rd   = 1'b1;
               end
            end else if (kind_cond) begin
               cnt_nx = cnt + 4'd1;
            end else begin
               state_nx = IDLE;
            end
         end
         ACTIVE_RD, ACTIVE_WR: begin
            if ((rd_s && wr_s) || !mreq_s || !m1_s) begin
               state_nx = RECOVER;
            end
         end
         RECOVER: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         kind          <= KIND_RD;
         cnt           <= 4'd0;
         rd_stb        <= 1'b0;
         wr_stb        <= 1'b0;
         io_addr       <= 16'h0000;
         io_data       <= 8'h00;
         rom_m1_access <= 1'b0;
      end else begin
         state  <= state_nx;
         kind   <= kind_nx;
         cnt    <= cnt_nx;
         rd_stb <= acc_rd;
         wr_stb <= acc_wr;
         if (acc_rd || acc_wr) begin
            io_addr <= a_q;
         end
         if (acc_wr) begin
            io_data <= d_q;
         end
         if (!m1_s && !mreq_s) begin
            rom_m1_access <= in_rom(a_q);
         end
      end
   end

   assign io_rd = (state == ACTIVE_RD);
   assign io_wr = (state == ACTIVE_WR);
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_zx_io_cycle_detect.sv
// Randomised and directed bench for zx_io_cycle_detect against a transaction-level model.
module tb_zx_io_cycle_detect;

   localparam int SYNC   = 2;
   localparam int SETTLE = 3;
   localparam int LAT    = SYNC + SETTLE;

   localparam int K_RD   = 0;
   localparam int K_WR   = 1;
   localparam int K_BOTH = 2;
   localparam int K_MEM  = 3;

   logic        clk32 = 1'b0;
   logic        rst_n;
   logic [15:0] a;
   logic [7:0]  d;
   logic        n_rd, n_wr, n_mreq, n_m1;
   logic        io_rd, io_wr, rd_stb, wr_stb, rom_m1_access, busy;
   logic [15:0] io_addr;
   logic [7:0]  io_data;

   zx_io_cycle_detect #(.SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE)) dut (
      .clk32(clk32), .rst_n(rst_n), .a(a), .d(d),
      .n_rd(n_rd), .n_wr(n_wr), .n_mreq(n_mreq), .n_m1(n_m1),
      .io_rd(io_rd), .io_wr(io_wr), .rd_stb(rd_stb), .wr_stb(wr_stb),
      .io_addr(io_addr), .io_data(io_data),
      .rom_m1_access(rom_m1_access), .busy(busy)
   );

   always #16 clk32 = ~clk32;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_addr;
   logic [7:0]  exp_data;
   logic        exp_rom;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one bus cycle of `len` clk32 samples, then `gap` idle samples, and checks
   // the result against the expected behaviour derived from the cycle's kind and length.
   task automatic run_cycle(input int kind, input logic [15:0] addr, input logic [7:0] data,
                            input int len, input int gap, input int abort_t);
      int  n_rd_stb = 0;
      int  n_wr_stb = 0;
      int  first_t  = -1;
      int  io_cnt   = 0;
      int  busy_cnt = 0;
      int  rel, exit_e, exp_io;
      bit  io_kind, accepted;
      a = addr;
      d = data;
      case (kind)
         K_RD:    n_rd = 1'b0;
         K_WR:    n_wr = 1'b0;
         K_BOTH:  begin n_rd = 1'b0; n_wr = 1'b0; end
         default: begin n_wr = 1'b0; n_mreq = 1'b0; end
      endcase
      for (int t = 0; t < len + gap; t++) begin
         @(posedge clk32);
         @(negedge clk32);
         if (rd_stb) begin n_rd_stb++; if (first_t < 0) first_t = t; end
         if (wr_stb) begin n_wr_stb++; if (first_t < 0) first_t = t; end
         if (io_rd || io_wr) io_cnt++;
         if (busy) busy_cnt++;
         if (t == abort_t) n_m1 = 1'b0;
         if (t == len - 1) begin
            n_rd = 1'b1; n_wr = 1'b1; n_mreq = 1'b1; n_m1 = 1'b1;
         end
      end
      io_kind  = (kind == K_RD) || (kind == K_WR);
      accepted = io_kind && (len >= SETTLE);
      rel      = (abort_t >= 0 && abort_t + 1 < len) ? abort_t + 1 : len;
      exit_e   = (rel + SYNC > LAT + 1) ? rel + SYNC : LAT + 1;
      exp_io   = accepted ? exit_e - LAT : 0;
      check_eq("rd_stb_count", 32'(n_rd_stb), 32'((accepted && kind == K_RD) ? 1 : 0));
      check_eq("wr_stb_count", 32'(n_wr_stb), 32'((accepted && kind == K_WR) ? 1 : 0));
      if (accepted) check_eq("stb_latency", 32'(first_t), 32'(LAT));
      check_eq("io_level_cycles", 32'(io_cnt), 32'(exp_io));
      check_eq("busy_seen", 32'(busy_cnt > 0), 32'(io_kind));
      if (accepted) exp_addr = addr;
      if (accepted && kind == K_WR) exp_data = data;
      check_eq("io_addr", 32'(io_addr), 32'(exp_addr));
      check_eq("io_data", 32'(io_data), 32'(exp_data));
   endtask

   task automatic fetch(input logic [15:0] addr);
      int stbs = 0;
      int bsy  = 0;
      a = addr; n_m1 = 1'b0; n_mreq = 1'b0; n_rd = 1'b0;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk32);
         if (rd_stb || wr_stb) stbs++;
         if (busy) bsy++;
         if (t == 3) begin n_m1 = 1'b1; n_mreq = 1'b1; n_rd = 1'b1; end
      end
      exp_rom = (addr[15:14] == 2'b00);
      check_eq("rom_m1_access", 32'(rom_m1_access), 32'(exp_rom));
      check_eq("fetch_no_io", 32'(stbs + bsy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int kind, len, gap, stbs, bsy;
      n_rd = 1'b1; n_wr = 1'b1; n_mreq = 1'b1; n_m1 = 1'b1;
      a = 16'h0000; d = 8'h00;
      rst_n = 1'b1;
      #5 rst_n = 1'b0;
      exp_addr = 16'h0000; exp_data = 8'h00; exp_rom = 1'b0;
      repeat (2) @(negedge clk32);
      check_eq("rst_io_rd", 32'(io_rd), 32'd0);
      check_eq("rst_io_wr", 32'(io_wr), 32'd0);
      check_eq("rst_stbs", 32'({rd_stb, wr_stb}), 32'd0);
      check_eq("rst_io_addr", 32'(io_addr), 32'h0000);
      check_eq("rst_io_data", 32'(io_data), 32'h00);
      check_eq("rst_rom", 32'(rom_m1_access), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk32);
      check_eq("idle_busy", 32'(busy), 32'd0);

      run_cycle(K_WR, 16'h00FE, 8'hA5, 18, 6, -1);
      run_cycle(K_RD, 16'hFFFD, 8'h77, 9, 6, -1);
      run_cycle(K_MEM, 16'h4000, 8'h11, 20, 6, -1);
      fetch(16'h0038);
      fetch(16'h8000);
      run_cycle(K_WR, 16'h00FE, 8'hEE, 2, 6, -1);
      run_cycle(K_BOTH, 16'h1FFD, 8'h22, 8, 6, -1);
      run_cycle(K_WR, 16'h00FE, 8'h01, 6, 3, -1);
      run_cycle(K_WR, 16'hBFFE, 8'h02, 6, 6, -1);
      run_cycle(K_RD, 16'h7FFE, 8'h00, 12, 6, 7);

      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 9);
         kind = (kind < 4) ? K_RD : (kind < 8) ? K_WR : (kind == 8) ? K_BOTH : K_MEM;
         len  = $urandom_range(1, 12);
         gap  = $urandom_range(4, 7);
         run_cycle(kind, 16'($urandom), 8'($urandom), len, gap, -1);
         if ($urandom_range(0, 5) == 0) fetch(16'($urandom));
      end

      // Reset in the middle of an accepted write, with n_wr still held low afterwards.
      a = 16'h1234; d = 8'h5A; n_wr = 1'b0;
      repeat (8) @(negedge clk32);
      check_eq("pre_rst_io_wr", 32'(io_wr), 32'd1);
      @(posedge clk32);
      #3 rst_n = 1'b0;
      #1;
      exp_addr = 16'h0000; exp_data = 8'h00; exp_rom = 1'b0;
      check_eq("async_rst_io_wr", 32'(io_wr), 32'd0);
      check_eq("async_rst_busy", 32'(busy), 32'd0);
      check_eq("async_rst_io_addr", 32'(io_addr), 32'h0000);
      check_eq("async_rst_io_data", 32'(io_data), 32'h00);
      @(negedge clk32);
      rst_n = 1'b1;
      stbs = 0; bsy = 0;
      for (int t = 0; t < 12; t++) begin
         @(negedge clk32);
         if (rd_stb || wr_stb) stbs++;
         if (busy) bsy++;
      end
      check_eq("post_rst_no_stb", 32'(stbs), 32'd0);
      check_eq("post_rst_no_busy", 32'(bsy), 32'd0);
      n_wr = 1'b1;
      repeat (5) @(negedge clk32);
      run_cycle(K_WR, 16'h00FE, 8'h3C, 6, 6, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
